qcv_rf_wb_arbiter: RTL and testbench

Shares the single register-file write port (waddr/wdata/we) between two writeback requesters.
- Requester 0 is the in-order ALU/pipeline writeback and has high priority.
- Requester 1 is the long-latency LSU/mul-div writeback and has low priority, with starvation promotion.
- The winning write is registered for one cycle before driving the register file.
- The block also supplies RAW-hazard detection or bypass for the two combinational read ports.

---
 rtl/qcv_rf_wb_arbiter.sv | 90 +++++++++
 tb/tb_qcv_rf_wb_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/qcv_rf_wb_arbiter.sv
// Register-file writeback arbiter: two requesters share one registered write port,
// with starvation promotion for requester 1. Define RF_BYPASS_EN to forward the pending write.
module qcv_rf_wb_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        wb0_valid_i,
   output logic        wb0_ready_o,
   input  logic [4:0]  wb0_addr_i,
   input  logic [31:0] wb0_data_i,
   input  logic        wb1_valid_i,
   output logic        wb1_ready_o,
   input  logic [4:0]  wb1_addr_i,
   input  logic [31:0] wb1_data_i,
   output logic [4:0]  rf_waddr_o,
   output logic [31:0] rf_wdata_o,
   output logic        rf_we_o,
   input  logic [4:0]  raddr_a_i,
   input  logic [4:0]  raddr_b_i,
   input  logic [31:0] rf_rdata_a_i,
   input  logic [31:0] rf_rdata_b_i,
   output logic [31:0] rdata_a_o,
   output logic [31:0] rdata_b_o,
   output logic        raw_hazard_o,
   output logic        idle_o
);

   localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

   logic [3:0]  r_cnt;
   logic        w_promote;
   logic        w_grant0;
   logic        w_grant1;
   logic        w_any;
   logic [4:0]  w_addr;
   logic [31:0] w_data;
   logic        w_hit_a;
   logic        w_hit_b;

   always_comb begin
      w_promote = wb1_valid_i && (r_cnt == LP_LIMIT);
      w_grant1  = wb1_valid_i && (!wb0_valid_i || w_promote);
      w_grant0  = wb0_valid_i && !w_grant1;
      w_any     = w_grant0 || w_grant1;
      w_addr    = w_grant1 ? wb1_addr_i : wb0_addr_i;
      w_data    = w_grant1 ? wb1_data_i : wb0_data_i;
   end

   assign wb0_ready_o = w_grant0;
   assign wb1_ready_o = w_grant1;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rf_we_o    <= 1'b0;
         rf_waddr_o <= '0;
         rf_wdata_o <= '0;
         r_cnt      <= '0;
      end else begin
         // x0 writes still handshake but never reach the register file
         rf_we_o <= w_any && (w_addr != '0);
         if (w_any) begin
            rf_waddr_o <= w_addr;
            rf_wdata_o <= w_data;
         end
         if (!wb1_valid_i || w_grant1) begin
            r_cnt <= '0;
         end else if (r_cnt != LP_LIMIT) begin
            r_cnt <= r_cnt + 4'd1;
         end
      end
   end

   // The write registered this cycle commits on the next edge, so a same-cycle read is stale
   assign w_hit_a = rf_we_o && (raddr_a_i == rf_waddr_o) && (raddr_a_i != '0);
   assign w_hit_b = rf_we_o && (raddr_b_i == rf_waddr_o) && (raddr_b_i != '0);

`ifdef RF_BYPASS_EN
   assign rdata_a_o    = w_hit_a ? rf_wdata_o : rf_rdata_a_i;
   assign rdata_b_o    = w_hit_b ? rf_wdata_o : rf_rdata_b_i;
   assign raw_hazard_o = 1'b0;
`else
   assign rdata_a_o    = rf_rdata_a_i;
   assign rdata_b_o    = rf_rdata_b_i;
   assign raw_hazard_o = w_hit_a || w_hit_b;
`endif

   assign idle_o = !wb0_valid_i && !wb1_valid_i && !rf_we_o;

endmodule

// File: tb/tb_qcv_rf_wb_arbiter.sv
// Bench for qcv_rf_wb_arbiter: vector table, hand sequences and a randomized run
// against a register-file level reference model.
module tb_qcv_rf_wb_arbiter;

   localparam int unsigned LIMIT = 4;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        wb0_valid_i, wb1_valid_i;
   logic        wb0_ready_o, wb1_ready_o;
   logic [4:0]  wb0_addr_i, wb1_addr_i;
   logic [31:0] wb0_data_i, wb1_data_i;
   logic [4:0]  rf_waddr_o;
   logic [31:0] rf_wdata_o;
   logic        rf_we_o;
   logic [4:0]  raddr_a_i, raddr_b_i;
   logic [31:0] rf_rdata_a_i, rf_rdata_b_i;
   logic [31:0] rdata_a_o, rdata_b_o;
   logic        raw_hazard_o, idle_o;

   qcv_rf_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .wb0_valid_i(wb0_valid_i), .wb0_ready_o(wb0_ready_o),
      .wb0_addr_i(wb0_addr_i), .wb0_data_i(wb0_data_i),
      .wb1_valid_i(wb1_valid_i), .wb1_ready_o(wb1_ready_o),
      .wb1_addr_i(wb1_addr_i), .wb1_data_i(wb1_data_i),
      .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .rf_we_o(rf_we_o),
      .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i),
      .rf_rdata_a_i(rf_rdata_a_i), .rf_rdata_b_i(rf_rdata_b_i),
      .rdata_a_o(rdata_a_o), .rdata_b_o(rdata_b_o),
      .raw_hazard_o(raw_hazard_o), .idle_o(idle_o)
   );

   always #5 clk_i = ~clk_i;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: architectural register file plus the one pending write
   logic [31:0] m_rf [32];
   logic        m_we;
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata;
   int unsigned m_waited;

   logic        s_r0, s_r1, s_haz;
   logic [31:0] s_rda;

   typedef struct {
      logic        v0; logic [4:0] a0; logic [31:0] d0;
      logic        v1; logic [4:0] a1; logic [31:0] d1;
      logic        r0; logic r1;
      logic        we; logic [4:0] wa; logic [31:0] wd;
   } vec_t;
   vec_t vec [8];

   task automatic chk1(input string name, input logic act, input logic exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0b, expected %0b (t=%0t)", name, act, exp, $time);
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_waited = 0;
   endtask

   // Called just after a rising edge with inputs set; checks this cycle and the next edge's result
   task automatic run_cycle();
      logic g0, g1, ha, hb;
      logic [31:0] ea, eb;
      rf_rdata_a_i = m_rf[raddr_a_i];
      rf_rdata_b_i = m_rf[raddr_b_i];
      @(negedge clk_i);
      g1 = wb1_valid_i && (!wb0_valid_i || m_waited == LIMIT);
      g0 = wb0_valid_i && !g1;
      ha = m_we && (raddr_a_i == m_waddr) && (raddr_a_i != 0);
      hb = m_we && (raddr_b_i == m_waddr) && (raddr_b_i != 0);
`ifdef RF_BYPASS_EN
      ea = ha ? m_wdata : m_rf[raddr_a_i];
      eb = hb ? m_wdata : m_rf[raddr_b_i];
      chk1("raw_hazard", raw_hazard_o, 1'b0);
`else
      ea = m_rf[raddr_a_i];
      eb = m_rf[raddr_b_i];
      chk1("raw_hazard", raw_hazard_o, ha || hb);
`endif
      chk1("wb0_ready", wb0_ready_o, g0);
      chk1("wb1_ready", wb1_ready_o, g1);
      chk32("rdata_a", rdata_a_o, ea);
      chk32("rdata_b", rdata_b_o, eb);
      chk1("idle", idle_o, !wb0_valid_i && !wb1_valid_i && !m_we);
      s_r0 = wb0_ready_o; s_r1 = wb1_ready_o; s_haz = raw_hazard_o; s_rda = rdata_a_o;
      @(posedge clk_i);
      if (m_we) m_rf[m_waddr] = m_wdata;
      if (g0 || g1) begin
         m_waddr = g1 ? wb1_addr_i : wb0_addr_i;
         m_wdata = g1 ? wb1_data_i : wb0_data_i;
         m_we    = (m_waddr != 0);
      end else begin
         m_we = 1'b0;
      end
      if (!wb1_valid_i || g1) m_waited = 0;
      else if (m_waited < LIMIT) m_waited++;
      #1;
      chk1("rf_we", rf_we_o, m_we);
      chk32("rf_waddr", {27'd0, rf_waddr_o}, {27'd0, m_waddr});
      chk32("rf_wdata", rf_wdata_o, m_wdata);
   endtask

   task automatic set_req(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                          input logic v1, input logic [4:0] a1, input logic [31:0] d1);
      wb0_valid_i = v0; wb0_addr_i = a0; wb0_data_i = d0;
      wb1_valid_i = v1; wb1_addr_i = a1; wb1_data_i = d1;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) m_rf[i] = (i == 0) ? 32'd0 : 32'h1000_0000 + 32'(i);
      model_reset();
      vec[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF};
      vec[1] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF};
      vec[2] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h1234, 1'b0, 1'b1, 1'b0, 5'd0, 32'h1234};
      vec[3] = '{1'b1, 5'd4,  32'h44,       1'b1, 5'd3,  32'h33,   1'b1, 1'b0, 1'b1, 5'd4, 32'h44};
      vec[4] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  32'h33,   1'b0, 1'b1, 1'b1, 5'd3, 32'h33};
      vec[5] = '{1'b1, 5'd0,  32'h55,       1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b0, 5'd0, 32'h55};
      vec[6] = '{1'b1, 5'd9,  32'h99,       1'b1, 5'd10, 32'hAA,   1'b1, 1'b0, 1'b1, 5'd9, 32'h99};
      vec[7] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 1'b0, 1'b0, 5'd9, 32'h99};

      rst_ni = 1'b0;
      set_req(1'b0, '0, '0, 1'b0, '0, '0);
      raddr_a_i = '0; raddr_b_i = '0; rf_rdata_a_i = '0; rf_rdata_b_i = '0;
      #1;
      chk1("reset rf_we", rf_we_o, 1'b0);
      chk32("reset rf_waddr", {27'd0, rf_waddr_o}, 32'd0);
      chk32("reset rf_wdata", rf_wdata_o, 32'd0);
      chk1("reset idle", idle_o, 1'b1);
      wb1_valid_i = 1'b1; #1;
      chk1("reset wb1_ready alone", wb1_ready_o, 1'b1);
      wb0_valid_i = 1'b1; #1;
      chk1("reset wb0_ready", wb0_ready_o, 1'b1);
      chk1("reset wb1_ready blocked", wb1_ready_o, 1'b0);
      set_req(1'b0, '0, '0, 1'b0, '0, '0);
      #9 rst_ni = 1'b1;
      @(posedge clk_i); #1;

      for (int i = 0; i < 8; i++) begin
         set_req(vec[i].v0, vec[i].a0, vec[i].d0, vec[i].v1, vec[i].a1, vec[i].d1);
         run_cycle();
         chk1($sformatf("vec%0d ready0", i), s_r0, vec[i].r0);
         chk1($sformatf("vec%0d ready1", i), s_r1, vec[i].r1);
         chk1($sformatf("vec%0d we", i), rf_we_o, vec[i].we);
         chk32($sformatf("vec%0d waddr", i), {27'd0, rf_waddr_o}, {27'd0, vec[i].wa});
         chk32($sformatf("vec%0d wdata", i), rf_wdata_o, vec[i].wd);
      end

      // Continuous contention: requester 1 wins every fifth cycle
      set_req(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB2);
      for (int i = 0; i < 10; i++) begin
         run_cycle();
         chk1($sformatf("starve%0d ready1", i), s_r1, (i % 5) == 4);
         chk1($sformatf("starve%0d ready0", i), s_r0, (i % 5) != 4);
      end
      set_req(1'b0, '0, '0, 1'b0, '0, '0);
      run_cycle();

      // A gap in requester 1's valid restarts its wait
      for (int i = 0; i < 8; i++) begin
         set_req(1'b1, 5'd1, 32'hC1, i != 2, 5'd2, 32'hD2);
         run_cycle();
         chk1($sformatf("drop%0d ready1", i), s_r1, i == 7);
      end
      set_req(1'b0, '0, '0, 1'b0, '0, '0);
      run_cycle();

      // Same destination from both: grant order decides the final value
      set_req(1'b1, 5'd12, 32'hA0, 1'b1, 5'd12, 32'hB1);
      run_cycle();
      chk32("samereg first", rf_wdata_o, 32'hA0);
      set_req(1'b0, '0, '0, 1'b1, 5'd12, 32'hB1);
      run_cycle();
      chk32("samereg second", rf_wdata_o, 32'hB1);
      chk32("samereg addr", {27'd0, rf_waddr_o}, 32'd12);
      set_req(1'b0, '0, '0, 1'b0, '0, '0);
      run_cycle();

      // Read of the pending write's register
      set_req(1'b1, 5'd7, 32'h77, 1'b0, '0, '0);
      run_cycle();
      set_req(1'b0, '0, '0, 1'b0, '0, '0);
      raddr_a_i = 5'd7; raddr_b_i = 5'd0;
      run_cycle();
`ifdef RF_BYPASS_EN
      chk1("hazard x7", s_haz, 1'b0);
      chk32("hazard rdata_a", s_rda, 32'h77);
`else
      chk1("hazard x7", s_haz, 1'b1);
      chk32("hazard rdata_a", s_rda, 32'h1000_0007);
`endif
      raddr_a_i = '0;

      // Asynchronous reset while a write is pending
      set_req(1'b1, 5'd9, 32'h909, 1'b0, '0, '0);
      run_cycle();
      chk1("pre-reset we", rf_we_o, 1'b1);
      set_req(1'b0, '0, '0, 1'b0, '0, '0);
      rst_ni = 1'b0;
      #1;
      chk1("async reset we", rf_we_o, 1'b0);
      chk32("async reset waddr", {27'd0, rf_waddr_o}, 32'd0);
      chk32("async reset wdata", rf_wdata_o, 32'd0);
      chk1("async reset idle", idle_o, 1'b1);
      model_reset();
      #2 rst_ni = 1'b1;
      run_cycle();

      // Randomized traffic with requesters holding until accepted
      s_r0 = 1'b0; s_r1 = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!wb0_valid_i || s_r0) begin
            wb0_valid_i = ($urandom_range(0, 2) != 0);
            wb0_addr_i  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            wb0_data_i  = $urandom;
         end
         if (!wb1_valid_i || s_r1) begin
            wb1_valid_i = ($urandom_range(0, 1) != 0);
            wb1_addr_i  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            wb1_data_i  = $urandom;
         end
         raddr_a_i = ($urandom_range(0, 1) != 0) ? m_waddr : 5'($urandom_range(0, 31));
         raddr_b_i = ($urandom_range(0, 1) != 0) ? m_waddr : 5'($urandom_range(0, 31));
         run_cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
